// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode seven-segment driver with double-buffered value.
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan #(
  parameter int unsigned DWELL_TICKS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk1khz,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_done
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_TICKS - 1);
  localparam logic [6:0] SEG_OFF    = 7'b1111111;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic [15:0] shd_val_q, shd_val_d;
  logic [3:0]  shd_dp_q, shd_dp_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_n_q, dp_n_d;
  logic        fd_q, fd_d;
  logic [3:0]  nib;
  logic        blank;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // A load on the same edge as a frame swap goes straight to the display.
  assign pend_val_d = load ? value : pend_val_q;
  assign pend_dp_d  = load ? dp    : pend_dp_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dwell_d   = dwell_q;
    shd_val_d = shd_val_q;
    shd_dp_d  = shd_dp_q;
    fd_d      = 1'b0;
    if (clk1khz) begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_SCAN;
          shd_val_d = pend_val_d;
          shd_dp_d  = pend_dp_d;
        end
        ST_SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = 8'd0;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              shd_val_d = pend_val_d;
              shd_dp_d  = pend_dp_d;
              fd_d      = 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    unique case (idx_d)
      2'd0: nib = shd_val_d[3:0];
      2'd1: nib = shd_val_d[7:4];
      2'd2: nib = shd_val_d[11:8];
      default: nib = shd_val_d[15:12];
    endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    unique case (idx_d)
      2'd0: blank = 1'b0;
      2'd1: blank = (shd_val_d[15:4] == 12'h000);
      2'd2: blank = (shd_val_d[15:8] == 8'h00);
      default: blank = (shd_val_d[15:12] == 4'h0);
    endcase
`else
    blank = 1'b0;
`endif
  end

  always_comb begin
    an_d   = 4'hF;
    seg_d  = SEG_OFF;
    dp_n_d = 1'b1;
    if (state_d == ST_SCAN) begin
      an_d   = ~(4'b0001 << idx_d);
      seg_d  = blank ? SEG_OFF : hex7(nib);
      dp_n_d = ~shd_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      dwell_q    <= 8'd0;
      pend_val_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      shd_val_q  <= 16'h0000;
      shd_dp_q   <= 4'h0;
      an_q       <= 4'hF;
      seg_q      <= SEG_OFF;
      dp_n_q     <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dwell_q    <= dwell_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      shd_val_q  <= shd_val_d;
      shd_dp_q   <= shd_dp_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_n_q     <= dp_n_d;
      fd_q       <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: vector table, corner sequences and random traffic
// against a tick-count reference model, on DWELL_TICKS=1 and =3 instances.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk1khz = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic        load = 1'b0;

  logic [3:0] an1, an3;
  logic [6:0] seg1, seg3;
  logic       dpn1, dpn3, fd1, fd3;
  logic [12:0] o1, o3;

  int checks = 0;
  int errors = 0;

  localparam logic [12:0] BLANK = {4'hF, 7'h7F, 1'b1, 1'b0};

  always #5 clk = ~clk;

  seg7_scan #(.DWELL_TICKS(1)) u_dut1 (
    .clk(clk), .reset(reset), .clk1khz(clk1khz), .value(value), .dp(dp),
    .load(load), .an(an1), .seg(seg1), .dp_n(dpn1), .frame_done(fd1)
  );

  seg7_scan #(.DWELL_TICKS(3)) u_dut3 (
    .clk(clk), .reset(reset), .clk1khz(clk1khz), .value(value), .dp(dp),
    .load(load), .an(an3), .seg(seg3), .dp_n(dpn3), .frame_done(fd3)
  );

  assign o1 = {an1, seg1, dpn1, fd1};
  assign o3 = {an3, seg3, dpn3, fd3};

  // Reference model: position derived from ticks elapsed since the start pulse.
  logic [6:0]  segtab [16];
  int          dw [2];
  bit          m_started [2];
  int          m_n [2];
  logic [15:0] m_pend;
  logic [3:0]  m_pend_dp;
  logic [15:0] m_shd [2];
  logic [3:0]  m_shd_dp [2];
  bit          m_fd [2];

  function automatic logic [12:0] exp_out(int k);
    int i;
    logic [15:0] up;
    logic [6:0] s;
    logic [3:0] a;
    if (!m_started[k]) return BLANK;
    i = (m_n[k] / dw[k]) % 4;
    up = m_shd[k] >> (4 * i);
    s = segtab[up[3:0]];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (i > 0 && up == 16'h0) s = 7'h7F;
`endif
    a = 4'hF ^ 4'(1 << i);
    return {a, s, ~m_shd_dp[k][i], m_fd[k]};
  endfunction

  task automatic model_reset();
    m_pend = 16'h0;
    m_pend_dp = 4'h0;
    for (int k = 0; k < 2; k++) begin
      m_started[k] = 0;
      m_n[k] = 0;
      m_shd[k] = 16'h0;
      m_shd_dp[k] = 4'h0;
      m_fd[k] = 0;
    end
  endtask

  task automatic model_step(bit t, bit ld, logic [15:0] v, logic [3:0] d);
    logic [15:0] np;
    logic [3:0] npd;
    np  = ld ? v : m_pend;
    npd = ld ? d : m_pend_dp;
    for (int k = 0; k < 2; k++) begin
      m_fd[k] = 0;
      if (t) begin
        if (!m_started[k]) begin
          m_started[k] = 1;
          m_n[k] = 0;
          m_shd[k] = np;
          m_shd_dp[k] = npd;
        end else begin
          m_n[k]++;
          if (m_n[k] % (4 * dw[k]) == 0) begin
            m_shd[k] = np;
            m_shd_dp[k] = npd;
            m_fd[k] = 1;
          end
        end
      end
    end
    m_pend = np;
    m_pend_dp = npd;
  endtask

  task automatic chk(string nm, logic [12:0] got, logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step(bit t, bit ld, logic [15:0] v, logic [3:0] d);
    clk1khz = t;
    load = ld;
    value = v;
    dp = d;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(t, ld, v, d);
    #1;
    chk("model_dw1", o1, exp_out(0));
    chk("model_dw3", o3, exp_out(1));
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    chk("async_rst_dw1", o1, BLANK);
    chk("async_rst_dw3", o3, BLANK);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit          t;
    bit          ld;
    logic [15:0] v;
    logic [3:0]  d;
    logic [12:0] exp;
  } vec_t;

  vec_t vt [7];
  int nfd1, nfd3;

  initial begin
    segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    dw = '{1, 3};
    vt[0] = '{0, 1, 16'h12AF, 4'b0010, BLANK};
    vt[1] = '{1, 0, 16'h0, 4'h0, {4'b1110, 7'b0001110, 1'b1, 1'b0}};
    vt[2] = '{1, 0, 16'h0, 4'h0, {4'b1101, 7'b0001000, 1'b0, 1'b0}};
    vt[3] = '{1, 0, 16'h0, 4'h0, {4'b1011, 7'b0100100, 1'b1, 1'b0}};
    vt[4] = '{1, 0, 16'h0, 4'h0, {4'b0111, 7'b1111001, 1'b1, 1'b0}};
    vt[5] = '{1, 0, 16'h0, 4'h0, {4'b1110, 7'b0001110, 1'b1, 1'b1}};
    vt[6] = '{0, 0, 16'h0, 4'h0, {4'b1110, 7'b0001110, 1'b1, 1'b0}};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dw1", o1, BLANK);
    chk("reset_dw3", o3, BLANK);
    reset = 1'b0;

    for (int i = 0; i < 100; i++) begin
      step(0, 0, 16'h0, 4'h0);
      chk("idle_blank", o1, BLANK);
    end

    for (int i = 0; i < 7; i++) begin
      step(vt[i].t, vt[i].ld, vt[i].v, vt[i].d);
      chk($sformatf("vec%0d", i), o1, vt[i].exp);
    end

    // reset mid-frame, held for two edges
    reset = 1'b1;
    #1;
    chk("async_rst_dw1", o1, BLANK);
    chk("async_rst_dw3", o3, BLANK);
    step(1, 1, 16'hFFFF, 4'hF);
    step(1, 0, 16'h0, 4'h0);
    reset = 1'b0;

    // mid-frame load while displaying 0000
    step(1, 0, 16'h0, 4'h0);
    step(1, 0, 16'h0, 4'h0);
    step(0, 1, 16'h1234, 4'h0);
    step(1, 0, 16'h0, 4'h0);
    chk("midload_d2", {6'b0, seg1}, {6'b0, 7'b1000000});
    step(1, 0, 16'h0, 4'h0);
    chk("midload_d3", {6'b0, seg1}, {6'b0, 7'b1000000});
    step(1, 0, 16'h0, 4'h0);
    chk("midload_wrap", {6'b0, seg1, fd1}, {6'b0, 7'b0011001, 1'b1});

    // load on the wrap edge overrides older pending value
    step(0, 1, 16'h5555, 4'h0);
    step(1, 0, 16'h0, 4'h0);
    step(1, 0, 16'h0, 4'h0);
    step(1, 0, 16'h0, 4'h0);
    step(1, 1, 16'hBEEF, 4'h0);
    chk("wrapload_d0", {5'b0, an1, seg1}, {5'b0, 4'b1110, 7'b0001110});
    step(1, 0, 16'h0, 4'h0);
    chk("wrapload_d1", {6'b0, seg1}, {6'b0, 7'b0000110});

    // leading zero handling on 0050
    step(0, 1, 16'h0050, 4'h0);
    step(1, 0, 16'h0, 4'h0);
    step(1, 0, 16'h0, 4'h0);
    step(1, 0, 16'h0, 4'h0);
    chk("lz_d0", {6'b0, seg1}, {6'b0, 7'b1000000});
    step(1, 0, 16'h0, 4'h0);
    chk("lz_d1", {6'b0, seg1}, {6'b0, 7'b0010010});
    step(1, 0, 16'h0, 4'h0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk("lz_d2", {2'b0, an1, seg1}, {2'b0, 4'b1011, 7'b1111111});
`else
    chk("lz_d2", {2'b0, an1, seg1}, {2'b0, 4'b1011, 7'b1000000});
`endif
    step(1, 0, 16'h0, 4'h0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk("lz_d3", {2'b0, an1, seg1}, {2'b0, 4'b0111, 7'b1111111});
`else
    chk("lz_d3", {2'b0, an1, seg1}, {2'b0, 4'b0111, 7'b1000000});
`endif

    // frame rate: 24 ticks after start
    async_reset();
    step(1, 0, 16'h0, 4'h0);
    nfd1 = 0;
    nfd3 = 0;
    for (int i = 0; i < 24; i++) begin
      step(1, 0, 16'h0, 4'h0);
      if (fd1) nfd1++;
      if (fd3) nfd3++;
      if (i == 1) chk("dw3_hold", {9'b0, an3}, {9'b0, 4'b1110});
      if (i == 2) chk("dw3_adv", {9'b0, an3}, {9'b0, 4'b1101});
    end
    chk("fd_count_dw1", 13'(nfd1), 13'd6);
    chk("fd_count_dw3", 13'(nfd3), 13'd2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
           16'($urandom), 4'($urandom));
    end

    clk1khz = 1'b0;
    load = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
